multi_slot_register_manager: RTL and testbench

- Parametrised successor to the single-slot P/Q register manager in the smart-parking datapath.
- Arbitrates access to N_SLOTS parking-slot register pairs:
  - the P register (token-authorised occupancy flag);
  - the Q register (entry time).
- Authenticates a user token against a per-system token, then accepts time data for the selected slot.
- Adds three behaviours the single-slot version lacks: confirm edge detection, a per-step timeout, and lockout after repeated bad tokens.

---
 rtl/parking_pkg.sv | 16 +
 rtl/rm_cycle_timer.sv | 37 +++
 rtl/multi_slot_register_manager.sv | 170 +++++++++++++++++
 tb/tb_multi_slot_register_manager.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared state encoding and default parameters for the slot register manager
package parking_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] AUTH = 2'd1;
  localparam logic [1:0] TIME = 2'd2;
  localparam logic [1:0] LOCK = 2'd3;

  localparam int DEF_TOKEN_W     = 3;
  localparam int DEF_TIME_W      = 8;
  localparam int DEF_N_SLOTS     = 2;
  localparam int DEF_TIMEOUT_CYC = 16;
  localparam int DEF_MAX_FAILS   = 3;
  localparam int DEF_LOCK_CYC    = 32;

endpackage

// File: rtl/rm_cycle_timer.sv
// rtl/rm_cycle_timer.sv - loadable saturating up/down cycle counter with terminal-count flag
module rm_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic         enable,
  input  logic         up,
  input  logic [W-1:0] load_value,
  input  logic [W-1:0] tc_value,
  output logic         tc
);

  logic [W-1:0] count;

  // Saturates at both ends so a stuck enable can never wrap the count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      if (up && count != '1) begin
        count <= count + 1'b1;
      end else if (!up && count != '0) begin
        count <= count - 1'b1;
      end
    end
  end

  assign tc = (count == tc_value);

endmodule

// File: rtl/multi_slot_register_manager.sv
// rtl/multi_slot_register_manager.sv - token-authorised P/Q register sequencer for N parking slots
module multi_slot_register_manager
  import parking_pkg::*;
#(
  parameter int TOKEN_W     = DEF_TOKEN_W,
  parameter int TIME_W      = DEF_TIME_W,
  parameter int N_SLOTS     = DEF_N_SLOTS,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int MAX_FAILS   = DEF_MAX_FAILS,
  parameter int LOCK_CYC    = DEF_LOCK_CYC,
  localparam int SEL_W      = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [TOKEN_W-1:0] system_token,
  input  logic [TOKEN_W-1:0] user_token,
  input  logic [TIME_W-1:0]  TimeData,
  input  logic [SEL_W-1:0]   slot_sel,
  input  logic               request,
  input  logic               confirm,
  output logic [N_SLOTS-1:0] P_register_enable,
  output logic [N_SLOTS-1:0] Q_register_enable,
  output logic [TIME_W-1:0]  time_out,
  output logic               auth_fail,
  output logic               timeout_err,
  output logic               locked
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int LW = $clog2(LOCK_CYC + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam logic [FW-1:0]    FAIL_LIMIT = FW'(MAX_FAILS);
  localparam logic [SEL_W:0]   SLOT_LIMIT = (SEL_W + 1)'(N_SLOTS);

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [SEL_W-1:0]   slot_q;
  logic               confirm_q;
  logic [FW-1:0]      fail_cnt;
  logic [FW-1:0]      fail_inc;
  logic               conf_rise;
  logic               in_wait;
  logic               tok_ok;
  logic               slot_ok;
  logic               step_tc;
  logic               step_clear;
  logic               lock_tc;
  logic               lock_load;
  logic               p_pulse;
  logic               q_pulse;
  logic               fail_pulse;
  logic               to_pulse;
  logic [N_SLOTS-1:0] slot_onehot;

  assign conf_rise   = confirm & ~confirm_q;
  assign in_wait     = (state == AUTH) || (state == TIME);
  assign tok_ok      = (user_token == system_token);
  assign slot_ok     = ({1'b0, slot_sel} < SLOT_LIMIT);
  assign fail_inc    = (fail_cnt == FAIL_LIMIT) ? fail_cnt : fail_cnt + 1'b1;
  assign slot_onehot = N_SLOTS'(1) << slot_q;

  // The step timer restarts on every state change and on every accepted confirm edge.
  assign step_clear = !in_wait || (state_next != state) || (request && conf_rise);
  assign lock_load  = (state_next == LOCK) && (state != LOCK);

  rm_cycle_timer #(.W(TW)) u_step_timer (
    .clock      (clock),
    .reset      (reset),
    .clear      (step_clear),
    .load       (1'b0),
    .enable     (in_wait),
    .up         (1'b1),
    .load_value ('0),
    .tc_value   (TW'(TIMEOUT_CYC - 1)),
    .tc         (step_tc)
  );

  // Counts down from LOCK_CYC; exit fires on the edge where the count leaves 1.
  rm_cycle_timer #(.W(LW)) u_lock_timer (
    .clock      (clock),
    .reset      (reset),
    .clear      (1'b0),
    .load       (lock_load),
    .enable     (state == LOCK),
    .up         (1'b0),
    .load_value (LW'(LOCK_CYC)),
    .tc_value   (LW'(1)),
    .tc         (lock_tc)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (request && slot_ok) state_next = AUTH;
      end
      AUTH: begin
        if (!request) begin
          state_next = IDLE;
        end else if (conf_rise) begin
          if (tok_ok)                       state_next = TIME;
          else if (fail_inc >= FAIL_LIMIT)  state_next = LOCK;
        end else if (step_tc) begin
          state_next = IDLE;
        end
      end
      TIME: begin
        if (!request || conf_rise || step_tc) state_next = IDLE;
      end
      LOCK: begin
        if (lock_tc) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Abort outranks a confirm edge, and a confirm edge outranks the timeout.
  always_comb begin
    p_pulse    = 1'b0;
    q_pulse    = 1'b0;
    fail_pulse = 1'b0;
    to_pulse   = 1'b0;
    if (in_wait && request) begin
      if (conf_rise) begin
        p_pulse    = (state == AUTH) && tok_ok;
        fail_pulse = (state == AUTH) && !tok_ok;
        q_pulse    = (state == TIME);
      end else begin
        to_pulse   = step_tc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      confirm_q         <= 1'b0;
      slot_q            <= '0;
      fail_cnt          <= '0;
      P_register_enable <= '0;
      Q_register_enable <= '0;
      time_out          <= '0;
      auth_fail         <= 1'b0;
      timeout_err       <= 1'b0;
      locked            <= 1'b0;
    end else begin
      confirm_q <= confirm;
      if (state == IDLE && state_next == AUTH) slot_q <= slot_sel;
      P_register_enable <= p_pulse ? slot_onehot : '0;
      Q_register_enable <= q_pulse ? slot_onehot : '0;
      if (q_pulse) time_out <= TimeData;
      auth_fail   <= fail_pulse;
      timeout_err <= to_pulse;
      locked      <= (state_next == LOCK);
      if ((state == LOCK && lock_tc) || p_pulse) begin
        fail_cnt <= '0;
      end else if (fail_pulse) begin
        fail_cnt <= fail_inc;
      end
    end
  end

endmodule

// File: tb/tb_multi_slot_register_manager.sv
// tb/tb_multi_slot_register_manager.sv - directed self-checking bench for multi_slot_register_manager
module tb_multi_slot_register_manager;
  import parking_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] system_token;
  logic [2:0] user_token;
  logic [7:0] TimeData;
  logic [0:0] slot_sel;
  logic       request;
  logic       confirm;
  logic [1:0] P_register_enable;
  logic [1:0] Q_register_enable;
  logic [7:0] time_out;
  logic       auth_fail;
  logic       timeout_err;
  logic       locked;

  int errors = 0;
  int checks = 0;
  int lock_len;
  logic [1:0] seen;

  multi_slot_register_manager dut (
    .clock             (clock),
    .reset             (reset),
    .system_token      (system_token),
    .user_token        (user_token),
    .TimeData          (TimeData),
    .slot_sel          (slot_sel),
    .request           (request),
    .confirm           (confirm),
    .P_register_enable (P_register_enable),
    .Q_register_enable (Q_register_enable),
    .time_out          (time_out),
    .auth_fail         (auth_fail),
    .timeout_err       (timeout_err),
    .locked            (locked)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; system_token = 3'b101; user_token = 3'b000; TimeData = 8'h00;
    slot_sel = 1'b1; request = 1'b0; confirm = 1'b0;
    step(); step();
    check("rst_p", 32'(P_register_enable), 32'h0);
    check("rst_q", 32'(Q_register_enable), 32'h0);
    check("rst_time", 32'(time_out), 32'h0);
    check("rst_err", 32'({auth_fail, timeout_err, locked}), 32'h0);
    check("rst_state", 32'(dut.state), 32'(IDLE));

    // nominal session on slot 1
    reset = 1'b1; request = 1'b1; step();
    user_token = 3'b101; confirm = 1'b1; step();
    check("nom_p", 32'(P_register_enable), 32'h2);
    check("nom_p_noq", 32'(Q_register_enable), 32'h0);
    confirm = 1'b0; TimeData = 8'h72; step();
    check("nom_p_drop", 32'(P_register_enable), 32'h0);
    confirm = 1'b1; step();
    check("nom_q", 32'(Q_register_enable), 32'h2);
    check("nom_time", 32'(time_out), 32'h72);
    request = 1'b0; confirm = 1'b0; step();
    check("nom_q_drop", 32'(Q_register_enable), 32'h0);
    check("nom_idle", 32'(dut.state), 32'(IDLE));

    // held confirm on slot 0
    slot_sel = 1'b0; request = 1'b1; step();
    confirm = 1'b1; step();
    check("held_p", 32'(P_register_enable), 32'h1);
    seen = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      seen = seen | Q_register_enable;
    end
    check("held_noq", 32'(seen), 32'h0);
    confirm = 1'b0; TimeData = 8'h3c; step();
    confirm = 1'b1; step();
    check("held_q", 32'(Q_register_enable), 32'h1);
    check("held_time", 32'(time_out), 32'h3c);
    request = 1'b0; confirm = 1'b0; step();

    // lockout after three bad tokens
    slot_sel = 1'b1; request = 1'b1; user_token = 3'b010; step();
    for (int i = 0; i < 3; i++) begin
      confirm = 1'b1; step();
      check($sformatf("lock_fail%0d", i), 32'(auth_fail), 32'h1);
      if (i < 2) begin
        confirm = 1'b0; step();
        check($sformatf("lock_fail_drop%0d", i), 32'(auth_fail), 32'h0);
        check($sformatf("lock_pre%0d", i), 32'(locked), 32'h0);
      end
    end
    check("lock_set", 32'(locked), 32'h1);
    user_token = 3'b101;
    lock_len = 1;
    seen = 2'b00;
    for (int k = 0; k < 100; k++) begin
      confirm = ~confirm;
      step();
      seen = seen | P_register_enable;
      if (!locked) break;
      lock_len++;
    end
    check("lock_len", 32'(lock_len), 32'd32);
    check("lock_nop", 32'(seen), 32'h0);
    request = 1'b0; confirm = 1'b0; step();
    check("lock_exit_idle", 32'(dut.state), 32'(IDLE));
    check("lock_fails_clr", 32'(dut.fail_cnt), 32'h0);

    // step timeout in AUTH
    request = 1'b1; slot_sel = 1'b0; step();
    seen = 2'b00;
    for (int i = 0; i < 15; i++) begin
      step();
      seen[0] = seen[0] | timeout_err;
    end
    check("to_early", 32'(seen), 32'h0);
    step();
    check("to_pulse", 32'(timeout_err), 32'h1);
    check("to_idle", 32'(dut.state), 32'(IDLE));
    check("to_en", 32'({P_register_enable, Q_register_enable}), 32'h0);
    request = 1'b0; step();
    check("to_drop", 32'(timeout_err), 32'h0);

    // abort in TIME: request drop beats confirm edge
    request = 1'b1; slot_sel = 1'b1; step();
    confirm = 1'b1; step();
    check("abort_p", 32'(P_register_enable), 32'h2);
    confirm = 1'b0; TimeData = 8'h99; step();
    confirm = 1'b1; request = 1'b0; step();
    check("abort_noq", 32'(Q_register_enable), 32'h0);
    check("abort_idle", 32'(dut.state), 32'(IDLE));
    check("abort_time", 32'(time_out), 32'h3c);
    confirm = 1'b0; step();

    // reset during lockout
    request = 1'b1; user_token = 3'b011; step();
    for (int i = 0; i < 3; i++) begin
      confirm = 1'b1; step();
      confirm = 1'b0; step();
    end
    check("rlock_locked", 32'(locked), 32'h1);
    reset = 1'b0; step();
    check("rlock_unlocked", 32'(locked), 32'h0);
    check("rlock_outs", 32'({P_register_enable, Q_register_enable, auth_fail, timeout_err}), 32'h0);
    check("rlock_time", 32'(time_out), 32'h0);
    check("rlock_idle", 32'(dut.state), 32'(IDLE));
    reset = 1'b1; request = 1'b0; step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
